// File: rtl/uart_pkg.sv
// -----------------------------------------------------------------------------
// uart_pkg
// Shared definitions for the UART receiver: receiver FSM state encoding,
// oversampling and frame-size constants, and the baud divider calculation.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

package uart_pkg;

  localparam int OVERSAMPLE = 16;  // oversample ticks per serial bit
  localparam int DATA_BITS  = 8;   // 8N1 payload width

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    STOP,
    WAIT_HIGH
  } rx_state_e;

  // Clocks per oversample tick; integer truncation is intentional
  // (100 MHz / (115200 * 16) = 54).
  function automatic int calc_div(input int clk_freq, input int baud);
    return clk_freq / (baud * OVERSAMPLE);
  endfunction

endpackage

// File: rtl/uart_rx_fifo.sv
// -----------------------------------------------------------------------------
// uart_rx_fifo
// Synchronous FIFO with a registered head output. The head register is
// reloaded every cycle with whatever will be at the head after this cycle's
// push/pop, so a byte pushed into an empty FIFO is on rd_data one cycle later.
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   push, push_data     write strobe and data (dropped when full unless popping)
//   pop                 read strobe (ignored when empty)
//   rd_data             registered head entry, meaningful while !empty
//   full, empty, count  occupancy status (count is 0..DEPTH)
//
// DEPTH must be a power of two and at least 2 so pointers wrap naturally.
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 4
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     push,
  input  logic [WIDTH-1:0]         push_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH) + 1;

  // NOTE: storage is deliberately not reset; only pointers, count and the head
  // register are, which is all that defines what the outside world sees.
  logic [WIDTH-1:0] mem [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [WIDTH-1:0] rd_data_q, rd_data_d;
  logic             do_push, do_pop;

  assign full    = (count_q == CNT_W'(DEPTH));
  assign empty   = (count_q == '0);
  assign count   = count_q;
  assign rd_data = rd_data_q;

  // NOTE: every signal driven here gets a default first, so no path through
  // the block leaves a value unassigned and no latch is inferred.
  always_comb begin
    do_pop    = pop && !empty;
    // A full FIFO still accepts a push when the same cycle frees a slot.
    do_push   = push && (!full || do_pop);
    wr_ptr_d  = wr_ptr_q + PTR_W'(do_push);
    rd_ptr_d  = rd_ptr_q + PTR_W'(do_pop);
    count_d   = count_q + CNT_W'(do_push) - CNT_W'(do_pop);
    rd_data_d = rd_data_q;
    if (count_d != '0) begin
      // The slot being written this cycle becomes the head only when it is
      // the sole entry afterwards; memory has not been updated yet.
      rd_data_d = (do_push && (wr_ptr_q == rd_ptr_d)) ? push_data : mem[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) begin
      mem[wr_ptr_q] <= push_data;
    end
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples
  // pre-edge values regardless of statement or process order.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q  <= '0;
      rd_ptr_q  <= '0;
      count_q   <= '0;
      rd_data_q <= '0;
    end else begin
      wr_ptr_q  <= wr_ptr_d;
      rd_ptr_q  <= rd_ptr_d;
      count_q   <= count_d;
      rd_data_q <= rd_data_d;
    end
  end

endmodule

// File: rtl/uart_rx.sv
// -----------------------------------------------------------------------------
// uart_rx
// 8N1 UART receiver with 16x oversampling and a small receive FIFO.
//
// Ports:
//   clk          system clock
//   reset        asynchronous active-low reset
//   UART_Rx      asynchronous serial input, idle high
//   rx_data      byte at FIFO head (registered), valid while rx_valid=1
//   rx_valid     FIFO not empty
//   rx_rd        pop strobe, ignored while rx_valid=0
//   rx_count     bytes held, 0..FIFO_DEPTH
//   frame_err    sticky: stop bit sampled low
//   overrun_err  sticky: byte completed while FIFO full and not popped
//   err_clr      one-cycle clear of both sticky flags (a new error wins)
// -----------------------------------------------------------------------------
`timescale 1ns/1ps

module uart_rx
  import uart_pkg::*;
#(
  parameter int CLK_FREQ   = 100_000_000,
  parameter int BAUD       = 115200,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                         clk,
  input  logic                         reset,
  input  logic                         UART_Rx,
  output logic [DATA_BITS-1:0]         rx_data,
  output logic                         rx_valid,
  input  logic                         rx_rd,
  output logic [$clog2(FIFO_DEPTH):0]  rx_count,
  output logic                         frame_err,
  output logic                         overrun_err,
  input  logic                         err_clr
);

  localparam int DIV    = calc_div(CLK_FREQ, BAUD);
  localparam int DIV_W  = (DIV > 1) ? $clog2(DIV) : 1;
  localparam int TICK_W = $clog2(OVERSAMPLE);
  localparam int BIT_W  = $clog2(DATA_BITS);

  localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(DIV - 1);
  localparam logic [TICK_W-1:0] HALF_TICK = TICK_W'(OVERSAMPLE / 2 - 1);
  localparam logic [TICK_W-1:0] LAST_TICK = TICK_W'(OVERSAMPLE - 1);
  localparam logic [BIT_W-1:0]  LAST_BIT  = BIT_W'(DATA_BITS - 1);

  logic [1:0]            sync_q, sync_d;
  rx_state_e             state_q, state_d;
  logic [DIV_W-1:0]      div_cnt_q, div_cnt_d;
  logic [TICK_W-1:0]     tick_cnt_q, tick_cnt_d;
  logic [BIT_W-1:0]      bit_cnt_q, bit_cnt_d;
  logic [DATA_BITS-1:0]  shift_q, shift_d;
  logic                  frame_err_q, frame_err_d;
  logic                  overrun_err_q, overrun_err_d;

  logic rx_s;
  logic tick;
  logic push_byte;
  logic frame_set;
  logic overrun_set;
  logic fifo_full;
  logic fifo_empty;

  // Two-stage synchronizer; only the second stage is ever looked at.
  assign sync_d = {sync_q[0], UART_Rx};
  assign rx_s   = sync_q[1];

  // Divider sits at zero in IDLE, so the first tick of a frame comes exactly
  // DIV clocks after the start edge is seen.
  assign tick = (state_q != IDLE) && (div_cnt_q == DIV_LAST);

  always_comb begin
    state_d    = state_q;
    tick_cnt_d = tick_cnt_q;
    bit_cnt_d  = bit_cnt_q;
    shift_d    = shift_q;
    push_byte  = 1'b0;
    frame_set  = 1'b0;
    div_cnt_d  = (state_q == IDLE || tick) ? '0 : div_cnt_q + DIV_W'(1);

    unique case (state_q)
      IDLE: begin
        tick_cnt_d = '0;
        bit_cnt_d  = '0;
        if (!rx_s) state_d = START;
      end
      START: begin
        // Re-check the line at mid start bit; a high line was a glitch.
        if (tick) begin
          if (tick_cnt_q == HALF_TICK) begin
            tick_cnt_d = '0;
            state_d    = rx_s ? IDLE : DATA;
          end else begin
            tick_cnt_d = tick_cnt_q + TICK_W'(1);
          end
        end
      end
      DATA: begin
        // Tick counter wraps every OVERSAMPLE ticks, landing on mid-bit.
        if (tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == LAST_TICK) begin
            shift_d   = {rx_s, shift_q[DATA_BITS-1:1]};
            bit_cnt_d = bit_cnt_q + BIT_W'(1);
            if (bit_cnt_q == LAST_BIT) state_d = STOP;
          end
        end
      end
      STOP: begin
        if (tick) begin
          tick_cnt_d = tick_cnt_q + TICK_W'(1);
          if (tick_cnt_q == LAST_TICK) begin
            if (rx_s) begin
              push_byte = 1'b1;
              state_d   = IDLE;
            end else begin
              frame_set = 1'b1;
              state_d   = WAIT_HIGH;
            end
          end
        end
      end
      WAIT_HIGH: begin
        // A low stop bit may be a break; wait for idle before hunting again.
        if (rx_s) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // A pop in the same cycle makes room, so only an unpopped full FIFO drops.
  assign overrun_set   = push_byte && fifo_full && !rx_rd;
  assign frame_err_d   = frame_set   || (frame_err_q   && !err_clr);
  assign overrun_err_d = overrun_set || (overrun_err_q && !err_clr);

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync_q        <= 2'b11;
      state_q       <= IDLE;
      div_cnt_q     <= '0;
      tick_cnt_q    <= '0;
      bit_cnt_q     <= '0;
      shift_q       <= '0;
      frame_err_q   <= 1'b0;
      overrun_err_q <= 1'b0;
    end else begin
      sync_q        <= sync_d;
      state_q       <= state_d;
      div_cnt_q     <= div_cnt_d;
      tick_cnt_q    <= tick_cnt_d;
      bit_cnt_q     <= bit_cnt_d;
      shift_q       <= shift_d;
      frame_err_q   <= frame_err_d;
      overrun_err_q <= overrun_err_d;
    end
  end

  uart_rx_fifo #(
    .WIDTH (DATA_BITS),
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk       (clk),
    .rst_n     (reset),
    .push      (push_byte),
    .push_data (shift_q),
    .pop       (rx_rd),
    .rd_data   (rx_data),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (rx_count)
  );

  assign rx_valid    = !fifo_empty;
  assign frame_err   = frame_err_q;
  assign overrun_err = overrun_err_q;

endmodule
